dll_track_ctrl: RTL

- Downstream of the 10-bit SAR in the FMDLL loop.
- During coarse acquisition it forwards the SAR code to the delay-line (DCDL) control bus.
- Once the SAR search completes, it takes ownership of the code and runs filtered ±1 LSB tracking driven by the phase-detector COMP.
- Flags lock when the tracking loop dithers around a stable code.

---
 rtl/dll_track_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dll_track_ctrl.sv
// rtl/dll_track_ctrl.sv - SAR hand-off and filtered +/-1 LSB DCDL tracking with lock detect
// Optional: define TRACK_FREEZE_EN to hold the code while locked (unanimous windows still step).
module dll_track_ctrl #(
  parameter int WIDTH        = 10,
  parameter int SAR_CYCLES   = 10,
  parameter int FILT_LEN     = 8,
  parameter int FILT_TH      = 6,
  parameter int LOCK_TOGGLES = 4
) (
  input  logic             clk4,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sar_q,
  input  logic             comp,
  input  logic             hold,
  output logic [WIDTH-1:0] dcdl_code,
  output logic             upd,
  output logic             tracking,
  output logic             locked
);

  localparam int CW = $clog2(SAR_CYCLES + 1);
  localparam int WW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  localparam int LW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(LOCK_TOGGLES + 1);

  localparam logic [CW-1:0]    CYC_LAST = CW'(SAR_CYCLES);
  localparam logic [WW-1:0]    WIN_LAST = WW'(FILT_LEN - 1);
  localparam logic [LW-1:0]    TH_UP    = LW'(FILT_TH);
  localparam logic [LW-1:0]    TH_DN    = LW'(FILT_LEN - FILT_TH);
  localparam logic [TW-1:0]    LOCK_N   = TW'(LOCK_TOGGLES);
  localparam logic [WIDTH-1:0] CODE_RST = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CODE_MAX = {WIDTH{1'b1}};

  typedef enum logic {S_SAR, S_TRACK} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WW-1:0]    win_q, win_d;
  logic [LW-1:0]    lead_q, lead_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             dir_up_q, dir_up_d;
  logic             dir_vld_q, dir_vld_d;
  logic             upd_q, upd_d;
  logic             trk_q, trk_d;
  logic             lock_q, lock_d;

  logic [LW-1:0]    total;
  logic             step_up;
  logic             step_dn;
  logic [TW-1:0]    tcnt_inc;
`ifdef TRACK_FREEZE_EN
  logic             unanimous;
`endif

  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SAR;
      cyc_q     <= '0;
      code_q    <= CODE_RST;
      win_q     <= '0;
      lead_q    <= '0;
      tcnt_q    <= '0;
      dir_up_q  <= 1'b0;
      dir_vld_q <= 1'b0;
      upd_q     <= 1'b0;
      trk_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      code_q    <= code_d;
      win_q     <= win_d;
      lead_q    <= lead_d;
      tcnt_q    <= tcnt_d;
      dir_up_q  <= dir_up_d;
      dir_vld_q <= dir_vld_d;
      upd_q     <= upd_d;
      trk_q     <= trk_d;
      lock_q    <= lock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    code_d    = code_q;
    win_d     = win_q;
    lead_d    = lead_q;
    tcnt_d    = tcnt_q;
    dir_up_d  = dir_up_q;
    dir_vld_d = dir_vld_q;
    upd_d     = 1'b0;
    trk_d     = trk_q;
    lock_d    = lock_q;
    total     = lead_q + LW'(comp);
    step_up   = 1'b0;
    step_dn   = 1'b0;
    tcnt_inc  = (tcnt_q == LOCK_N) ? tcnt_q : tcnt_q + TW'(1);
`ifdef TRACK_FREEZE_EN
    unanimous = (total == LW'(FILT_LEN)) || (total == '0);
`endif

    case (state_q)
      S_SAR: begin
        code_d = sar_q;
        cyc_d  = cyc_q + CW'(1);
        if (cyc_q == CYC_LAST) begin
          state_d   = S_TRACK;
          trk_d     = 1'b1;
          win_d     = '0;
          lead_d    = '0;
          tcnt_d    = '0;
          dir_vld_d = 1'b0;
          lock_d    = 1'b0;
        end
      end

      S_TRACK: begin
        if (!hold) begin
          if (win_q == WIN_LAST) begin
            upd_d   = 1'b1;
            win_d   = '0;
            lead_d  = '0;
            step_up = (total >= TH_UP);
            step_dn = !step_up && (total <= TH_DN);
`ifdef TRACK_FREEZE_EN
            if (lock_q && !unanimous) begin
              step_up = 1'b0;
              step_dn = 1'b0;
            end
`endif
            if (step_up && code_q != CODE_MAX) begin
              code_d = code_q + WIDTH'(1);
            end else if (step_dn && code_q != '0) begin
              code_d = code_q - WIDTH'(1);
            end

            // A saturated step still records its direction.
            if (step_up || step_dn) begin
              tcnt_d    = (dir_vld_q && (dir_up_q != step_up)) ? tcnt_inc : '0;
              dir_up_d  = step_up;
              dir_vld_d = 1'b1;
            end else begin
              tcnt_d = tcnt_inc;
            end
`ifdef TRACK_FREEZE_EN
            if (lock_q && (step_up || step_dn)) begin
              tcnt_d = '0;
            end
`endif
            lock_d = (tcnt_d == LOCK_N);
          end else begin
            win_d  = win_q + WW'(1);
            lead_d = total;
          end
        end
      end

      default: state_d = S_SAR;
    endcase
  end

  assign dcdl_code = code_q;
  assign upd       = upd_q;
  assign tracking  = trk_q;
  assign locked    = lock_q;

endmodule
